// File: rtl/serial_mem_pkg.sv
// Shared definitions for the serial command bridge: protocol bytes, FSM states
// and the geometry of the attached on-chip memory.
package serial_mem_pkg;

  localparam logic [7:0] OP_WRITE = 8'h57;  // 'W' : addr, data
  localparam logic [7:0] OP_READ  = 8'h52;  // 'R' : addr
  localparam logic [7:0] OP_DUMP  = 8'h44;  // 'D' : addr, cnt
  localparam logic [7:0] ACK_BYTE = 8'h06;

  localparam int unsigned MEM_AW = 8;
  localparam int unsigned MEM_DW = 8;

  typedef enum logic [2:0] {
    StIdle,
    StGetAddr,
    StGetData,
    StGetCnt,
    StWrIssue,
    StRdIssue,
    StRdCapture,
    StTxWait
  } cmd_state_t;

endpackage

// File: rtl/rx_timeout_counter.sv
// Inter-byte timeout counter.
// Ports:
//   clk, reset_n : clock, async active-low reset
//   clear        : restart the count (byte accepted or not waiting for operands)
//   enable       : count this cycle
//   expired      : single-cycle pulse on the TIMEOUT_CYCLES-th idle cycle
module rx_timeout_counter #(
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] LastCount = CntW'(TIMEOUT_CYCLES - 1);

  logic [CntW-1:0] count_q;

  // count_q holds the number of idle cycles already elapsed, so the current
  // cycle is the last allowed one when it equals TIMEOUT_CYCLES-1.
  assign expired = enable && !clear && (count_q == LastCount);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else if (clear || expired) begin
      count_q <= '0;
    end else if (enable) begin
      count_q <= count_q + 1'b1;
    end
  end

endmodule

// File: rtl/serial_mem_cmd_bridge.sv
// Byte-protocol command front-end for a 256 x 8 Avalon-MM on-chip memory.
// Ports:
//   clk, reset_n                 : clock, async active-low reset
//   rx_data, rx_valid            : received byte stream (no backpressure)
//   tx_data, tx_valid, tx_ready  : transmit byte stream (valid/ready)
//   mem_address, mem_chipselect,
//   mem_write, mem_writedata,
//   mem_readdata, mem_clken      : Avalon-MM master to the memory (1-cycle read latency)
//   busy                         : a command is in progress
//   err                          : pulse on timeout, unknown opcode or dropped byte
module serial_mem_cmd_bridge
  import serial_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [MEM_AW-1:0] mem_address,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [MEM_DW-1:0] mem_writedata,
  input  logic [MEM_DW-1:0] mem_readdata,
  output logic              mem_clken,
  output logic              busy,
  output logic              err
);

  cmd_state_t      state_q;
  logic [7:0]      opcode_q;
  logic [7:0]      remaining_q;  // bytes still to send after the current one
  logic            wait_operand;
  logic            timeout;

  assign mem_clken    = 1'b1;
  assign busy         = (state_q != StIdle);
  assign wait_operand = (state_q == StGetAddr) || (state_q == StGetData) ||
                        (state_q == StGetCnt);

  rx_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (rx_valid || !wait_operand),
    .enable  (wait_operand),
    .expired (timeout)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= StIdle;
      opcode_q       <= '0;
      remaining_q    <= '0;
      tx_data        <= '0;
      tx_valid       <= 1'b0;
      mem_address    <= '0;
      mem_chipselect <= 1'b0;
      mem_write      <= 1'b0;
      mem_writedata  <= '0;
      err            <= 1'b0;
    end else begin
      // Chipselect and write strobe are single-cycle issue pulses.
      err            <= 1'b0;
      mem_chipselect <= 1'b0;
      mem_write      <= 1'b0;

      unique case (state_q)
        StIdle: begin
          if (rx_valid) begin
            if (rx_data == OP_WRITE || rx_data == OP_READ || rx_data == OP_DUMP) begin
              opcode_q <= rx_data;
              state_q  <= StGetAddr;
            end else begin
              err <= 1'b1;
            end
          end
        end

        StGetAddr: begin
          if (rx_valid) begin
            mem_address <= rx_data;
            case (opcode_q)
              OP_WRITE: state_q <= StGetData;
              OP_DUMP:  state_q <= StGetCnt;
              default: begin
                remaining_q    <= '0;
                mem_chipselect <= 1'b1;
                state_q        <= StRdIssue;
              end
            endcase
          end else if (timeout) begin
            err     <= 1'b1;
            state_q <= StIdle;
          end
        end

        StGetData: begin
          if (rx_valid) begin
            mem_writedata  <= rx_data;
            mem_chipselect <= 1'b1;
            mem_write      <= 1'b1;
            state_q        <= StWrIssue;
          end else if (timeout) begin
            err     <= 1'b1;
            state_q <= StIdle;
          end
        end

        StGetCnt: begin
          if (rx_valid) begin
            remaining_q    <= rx_data;
            mem_chipselect <= 1'b1;
            state_q        <= StRdIssue;
          end else if (timeout) begin
            err     <= 1'b1;
            state_q <= StIdle;
          end
        end

        StWrIssue: begin
          err      <= rx_valid;
          tx_data  <= ACK_BYTE;
          tx_valid <= 1'b1;
          state_q  <= StTxWait;
        end

        // Memory samples the address at the end of this cycle.
        StRdIssue: begin
          err     <= rx_valid;
          state_q <= StRdCapture;
        end

        StRdCapture: begin
          err      <= rx_valid;
          tx_data  <= mem_readdata;
          tx_valid <= 1'b1;
          state_q  <= StTxWait;
        end

        StTxWait: begin
          err <= rx_valid;
          if (tx_ready) begin
            tx_valid <= 1'b0;
            if (remaining_q != 8'd0) begin
              mem_address    <= mem_address + 8'd1;
              remaining_q    <= remaining_q - 8'd1;
              mem_chipselect <= 1'b1;
              state_q        <= StRdIssue;
            end else begin
              state_q <= StIdle;
            end
          end
        end

        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_mem_cmd_bridge.sv
// Self-checking bench for serial_mem_cmd_bridge: memory slave model, byte-level
// reference model of the protocol, directed table, timing sequences, random run.
module tb_serial_mem_cmd_bridge;

  localparam int unsigned TO = 16;
  localparam int LogN = 8192;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready = 1'b1;
  logic [7:0] mem_address;
  logic       mem_chipselect;
  logic       mem_write;
  logic [7:0] mem_writedata;
  logic [7:0] mem_readdata = 8'h00;
  logic       mem_clken;
  logic       busy;
  logic       err;

  serial_mem_cmd_bridge #(
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .tx_data        (tx_data),
    .tx_valid       (tx_valid),
    .tx_ready       (tx_ready),
    .mem_address    (mem_address),
    .mem_chipselect (mem_chipselect),
    .mem_write      (mem_write),
    .mem_writedata  (mem_writedata),
    .mem_readdata   (mem_readdata),
    .mem_clken      (mem_clken),
    .busy           (busy),
    .err            (err)
  );

  always #5 clk = ~clk;

  // Memory slave: registered read data, one cycle latency.
  bit [7:0] mem_arr [256];
  always @(posedge clk) begin
    if (mem_chipselect) begin
      if (mem_write) mem_arr[mem_address] <= mem_writedata;
      mem_readdata <= mem_arr[mem_address];
    end
  end

  // Bus monitors.
  bit [7:0] tx_arr [LogN];
  int tx_n = 0, err_cnt = 0, wr_cnt = 0, rd_cnt = 0;
  always @(posedge clk) begin
    if (tx_valid && tx_ready) begin
      tx_arr[tx_n % LogN] <= tx_data;
      tx_n <= tx_n + 1;
    end
    if (err) err_cnt <= err_cnt + 1;
    if (mem_chipselect && mem_write) wr_cnt <= wr_cnt + 1;
    if (mem_chipselect && !mem_write) rd_cnt <= rd_cnt + 1;
  end

  // Transmit-side readiness: fixed or random per cycle.
  logic ready_ctl = 1'b1;
  bit   rand_mode = 1'b0;
  always @(negedge clk) tx_ready = rand_mode ? 1'($urandom_range(0, 1)) : ready_ctl;

  // Reference model: memory image as the protocol sees it.
  bit [7:0] ref_mem [256];
  typedef bit [7:0] byte_q_t[$];

  int tests = 0, fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 5000; i++) begin
      if (!busy) break;
      @(negedge clk);
    end
    chk({name, "_idle"}, 32'(busy), 32'd0);
  endtask

  task automatic send_cmd(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b);
    send_byte(op);
    send_byte(a);
    if (op != 8'h52) send_byte(b);
  endtask

  // Expected transmit bytes computed from the protocol rules alone.
  function automatic byte_q_t model(input logic [7:0] op, input logic [7:0] a,
                                    input logic [7:0] b);
    byte_q_t q;
    if (op == 8'h57) begin
      ref_mem[a] = b;
      q.push_back(8'h06);
    end else if (op == 8'h52) begin
      q.push_back(ref_mem[a]);
    end else begin
      for (int i = 0; i <= int'(b); i++) q.push_back(ref_mem[(int'(a) + i) % 256]);
    end
    return q;
  endfunction

  task automatic run_checked(input string name, input logic [7:0] op, input logic [7:0] a,
                             input logic [7:0] b);
    byte_q_t exp;
    int base;
    exp  = model(op, a, b);
    base = tx_n;
    send_cmd(op, a, b);
    wait_idle(name);
    chk({name, "_len"}, 32'(tx_n - base), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < tx_n - base; i++)
      chk({name, "_byte"}, 32'(tx_arr[(base + i) % LogN]), 32'(exp[i]));
  endtask

  typedef struct {
    logic [7:0] op;
    logic [7:0] a;
    logic [7:0] b;
    int         len;
    logic [7:0] last;
  } vec_t;

  vec_t tbl [10];

  initial begin
    int base, e0, w0, r0;
    logic [7:0] held, op, a, b;
    bit bad;

    tbl[0] = '{8'h57, 8'h10, 8'hA5, 1, 8'h06};
    tbl[1] = '{8'h52, 8'h10, 8'h00, 1, 8'hA5};
    tbl[2] = '{8'h57, 8'h11, 8'h3C, 1, 8'h06};
    tbl[3] = '{8'h57, 8'hFF, 8'h77, 1, 8'h06};
    tbl[4] = '{8'h57, 8'h00, 8'h81, 1, 8'h06};
    tbl[5] = '{8'h52, 8'h11, 8'h00, 1, 8'h3C};
    tbl[6] = '{8'h44, 8'h10, 8'h01, 2, 8'h3C};
    tbl[7] = '{8'h44, 8'hFF, 8'h01, 2, 8'h81};
    tbl[8] = '{8'h52, 8'hFF, 8'h00, 1, 8'h77};
    tbl[9] = '{8'h44, 8'h05, 8'h00, 1, 8'h00};

    reset_n  = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset_outs", 32'({tx_data, tx_valid, mem_address, mem_chipselect, mem_write,
                           mem_writedata, busy, err}), 32'd0);
    chk("clken", 32'(mem_clken), 32'd1);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Write timing: data accepted in N, write strobe in N+1, ACK valid in N+2.
    w0 = wr_cnt;
    base = tx_n;
    void'(model(8'h57, 8'h40, 8'h5A));
    send_byte(8'h57);
    send_byte(8'h40);
    send_byte(8'h5A);
    chk("wr_strobe", 32'({mem_chipselect, mem_write, mem_address, mem_writedata}),
        32'({1'b1, 1'b1, 8'h40, 8'h5A}));
    chk("wr_no_tx_yet", 32'(tx_valid), 32'd0);
    @(negedge clk);
    chk("wr_cs_low", 32'(mem_chipselect), 32'd0);
    chk("wr_ack", 32'({tx_valid, tx_data}), 32'({1'b1, 8'h06}));
    wait_idle("wr");
    chk("wr_count", 32'(wr_cnt - w0), 32'd1);
    chk("wr_txn", 32'(tx_n - base), 32'd1);

    // Read timing: addr in N, issue N+1, capture N+2, tx_valid N+3.
    base = tx_n;
    send_byte(8'h52);
    send_byte(8'h40);
    chk("rd_issue", 32'({mem_chipselect, mem_write, mem_address}), 32'({1'b1, 1'b0, 8'h40}));
    @(negedge clk);
    chk("rd_cap", 32'({mem_chipselect, tx_valid}), 32'd0);
    @(negedge clk);
    chk("rd_tx", 32'({tx_valid, tx_data}), 32'({1'b1, 8'h5A}));
    wait_idle("rd");
    chk("rd_txn", 32'(tx_n - base), 32'd1);

    // Directed table.
    for (int i = 0; i < 10; i++) begin
      base = tx_n;
      run_checked("tbl", tbl[i].op, tbl[i].a, tbl[i].b);
      chk("tbl_len_vec", 32'(tx_n - base), 32'(tbl[i].len));
      chk("tbl_last_vec", 32'(tx_arr[(tx_n - 1) % LogN]), 32'(tbl[i].last));
    end

    // Dump across the top of the address space.
    run_checked("pre_fe", 8'h57, 8'hFE, 8'h01);
    run_checked("pre_ff", 8'h57, 8'hFF, 8'h02);
    run_checked("pre_00", 8'h57, 8'h00, 8'h03);
    base = tx_n;
    run_checked("dump_wrap", 8'h44, 8'hFE, 8'h02);
    chk("dump_wrap_bytes", 32'({tx_arr[base % LogN], tx_arr[(base + 1) % LogN],
                                tx_arr[(base + 2) % LogN]}), 32'h010203);

    // Backpressure on a read.
    ready_ctl = 1'b0;
    repeat (2) @(negedge clk);
    base = tx_n;
    send_cmd(8'h52, 8'h10, 8'h00);
    for (int i = 0; i < 20 && !tx_valid; i++) @(negedge clk);
    chk("bp_valid", 32'(tx_valid), 32'd1);
    held = tx_data;
    r0 = rd_cnt;
    bad = 1'b0;
    repeat (50) begin
      @(negedge clk);
      if (!tx_valid || tx_data !== held) bad = 1'b1;
    end
    chk("bp_hold", 32'(bad), 32'd0);
    chk("bp_no_access", 32'(rd_cnt - r0), 32'd0);
    chk("bp_data", 32'(held), 32'(ref_mem[8'h10]));
    ready_ctl = 1'b1;
    wait_idle("bp");
    chk("bp_txn", 32'(tx_n - base), 32'd1);

    // Timeout between operands aborts the write.
    run_checked("to_pre", 8'h57, 8'h20, 8'hC3);
    e0 = err_cnt;
    w0 = wr_cnt;
    send_byte(8'h57);
    send_byte(8'h20);
    repeat (TO + 10) @(negedge clk);
    chk("to_err", 32'(err_cnt - e0), 32'd1);
    chk("to_idle", 32'(busy), 32'd0);
    chk("to_no_write", 32'(wr_cnt - w0), 32'd0);
    run_checked("to_readback", 8'h52, 8'h20, 8'h00);

    // Unknown opcode.
    e0 = err_cnt;
    base = tx_n;
    send_byte(8'h33);
    repeat (2) @(negedge clk);
    chk("unk_err", 32'(err_cnt - e0), 32'd1);
    chk("unk_idle", 32'(busy), 32'd0);
    chk("unk_no_tx", 32'(tx_n - base), 32'd0);

    // Randomized commands with random transmitter stalls.
    rand_mode = 1'b1;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 2))
        0:       op = 8'h57;
        1:       op = 8'h52;
        default: op = 8'h44;
      endcase
      a = 8'($urandom);
      b = (op == 8'h44) ? 8'($urandom_range(0, 7)) : 8'($urandom);
      if (i == 20) begin
        op = 8'h44;
        b  = 8'hFF;
      end
      run_checked("rand", op, a, b);
    end
    rand_mode = 1'b0;
    repeat (2) @(negedge clk);

    // Byte strobed while a dump waits on the transmitter.
    ready_ctl = 1'b0;
    repeat (2) @(negedge clk);
    begin
      byte_q_t exp;
      exp  = model(8'h44, 8'h30, 8'h03);
      base = tx_n;
      send_cmd(8'h44, 8'h30, 8'h03);
      for (int i = 0; i < 20 && !tx_valid; i++) @(negedge clk);
      chk("ovr_valid", 32'(tx_valid), 32'd1);
      e0 = err_cnt;
      send_byte(8'h52);
      @(negedge clk);
      chk("ovr_err", 32'(err_cnt - e0), 32'd1);
      ready_ctl = 1'b1;
      @(negedge clk);
      wait_idle("ovr");
      chk("ovr_len", 32'(tx_n - base), 32'(exp.size()));
      for (int i = 0; i < exp.size() && i < tx_n - base; i++)
        chk("ovr_byte", 32'(tx_arr[(base + i) % LogN]), 32'(exp[i]));
    end

    // Reset in the middle of a full dump.
    send_cmd(8'h44, 8'h00, 8'hFF);
    repeat (40) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_mid_outs", 32'({tx_data, tx_valid, mem_address, mem_chipselect, mem_write,
                             mem_writedata, busy, err}), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    run_checked("post_rst", 8'h52, 8'h00, 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global watchdog.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/serial_mem_cmd_bridge.md
# serial_mem_cmd_bridge

Command front-end between the UART byte stream and the 256 x 8 single-port on-chip memory. Parses a three-opcode byte protocol (write, read, dump), drives the memory's Avalon-MM slave port as a master, and returns read data or acknowledgements on the transmit byte stream. It sits directly upstream of the on-chip memory and downstream of the UART receiver, and also feeds the UART transmitter.

## Interface
- `TIMEOUT_CYCLES`, default 1_000_000: maximum idle cycles between operand bytes before a command is aborted.
- `clk` in 1: single clock for the whole block.
- `reset_n` in 1: asynchronous, active-low reset.
- `rx_data` in 8: received byte.
- `rx_valid` in 1: one-cycle strobe; no backpressure exists on the receive side.
- `tx_data` out 8: byte to transmit.
- `tx_valid` out 1: `tx_data` is valid.
- `tx_ready` in 1: transmitter accepts; a transfer occurs when `tx_valid & tx_ready`.
- `mem_address` out 8: memory address.
- `mem_chipselect` out 1: memory select.
- `mem_write` out 1: write enable, qualified by chipselect.
- `mem_writedata` out 8: write data.
- `mem_readdata` in 8: read data, valid exactly 1 cycle after the address is presented.
- `mem_clken` out 1: constant 1.
- `busy` out 1: high whenever the FSM is not in IDLE.
- `err` out 1: one-cycle pulse on timeout, unknown opcode, or a dropped byte.

## Operation
- Opcodes:
  - `0x57` W: followed by addr, data. Writes the data, then transmits ACK `0x06`.
  - `0x52` R: followed by addr. Transmits `mem[addr]`.
  - `0x44` D: followed by addr, cnt. Transmits cnt+1 bytes from addr upward (1 to 256 bytes). The address wraps `0xFF -> 0x00`.
- Any other byte received in IDLE: dropped, `err` pulses, FSM stays in IDLE.
- States and transitions:
  - IDLE -> GET_ADDR on a valid opcode.
  - GET_ADDR -> GET_DATA (W), RD_ISSUE (R), or GET_CNT (D).
  - GET_DATA -> WR_ISSUE.
  - GET_CNT -> RD_ISSUE.
  - WR_ISSUE -> TX_WAIT, loading ACK.
  - RD_ISSUE -> RD_CAPTURE -> TX_WAIT.
  - TX_WAIT, on handshake: go to RD_ISSUE with address+1 and remaining-1 if the remaining count is nonzero; otherwise go to IDLE.
- Byte arriving in WR_ISSUE, RD_ISSUE, RD_CAPTURE or TX_WAIT: dropped, `err` pulses, the current command continues.
- Timeout: a counter resets on every accepted byte and runs only in GET_ADDR, GET_DATA and GET_CNT. When it reaches `TIMEOUT_CYCLES`: `err` pulses and the FSM returns to IDLE with no memory access.
- Count and address registers are 8 bits; both wrap modulo 256.

## Timing
- Reset values:
  - `tx_data`=0, `tx_valid`=0.
  - `mem_address`=0, `mem_chipselect`=0, `mem_write`=0, `mem_writedata`=0.
  - `busy`=0, `err`=0.
  - State = IDLE; counters = 0.
- Reset asserted mid-command: everything returns to reset values immediately. An in-flight `tx_valid` is withdrawn.
- Write access: the data byte is accepted in cycle N. `mem_chipselect`=`mem_write`=1 for exactly one cycle, N+1. ACK `tx_valid` rises in N+2.
- Read access:
  - Final operand (or TX handshake during a dump) in cycle N.
  - Address driven with `mem_chipselect`=1, `mem_write`=0 in N+1.
  - `mem_readdata` registered into `tx_data` in N+2.
  - `tx_valid`=1 from N+3.
- `tx_data` is held stable while `tx_valid & !tx_ready`. `tx_valid` drops the cycle after the handshake.
- Dump throughput: 3 cycles per byte plus transmitter stall.
- `mem_chipselect` is low in every cycle other than an issue cycle.

## Structure
- Package `serial_mem_pkg` holds:
  - Opcode constants `OP_WRITE`, `OP_READ`, `OP_DUMP` and `ACK_BYTE`.
  - State enum `cmd_state_t`.
  - Memory width constants `MEM_AW`=8, `MEM_DW`=8.
- Sub-module `rx_timeout_counter`:
  - Inputs: `clear` and `enable`.
  - Output: `expired` pulse.
  - Width from `$clog2(TIMEOUT_CYCLES+1)`.
- Everything else is in one FSM module.

## Test plan
- Write then read: `57 10 A5`, then `52 10`. Required: `tx` sequence `06`, `A5`; exactly one write cycle with `mem_address`=0x10, `mem_writedata`=0xA5.
- Dump with wrap: preload `mem[FE]`=1, `mem[FF]`=2, `mem[00]`=3, then send `44 FE 02`. Required: `tx` = `01 02 03`, then `busy`=0.
- Backpressure: hold `tx_ready`=0 for 50 cycles during an R. Required: `tx_data` stable, `tx_valid` held high, no extra memory access.
- Timeout: send `57 20`, then silence for `TIMEOUT_CYCLES` (set to 16 in the bench). Required: `err` pulse, IDLE, no write; a following `52 20` returns the old value.
- Unknown opcode and overrun: send `33`. Required: `err` pulse. A byte strobed during a dump's TX_WAIT: `err` pulse, and the dump output is unchanged.
- Reset mid-dump: assert `reset_n`=0 during `44 00 FF`. Required: all outputs 0 asynchronously; after release, `52 00` works normally.
